// File: rtl/lsu_mem_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl_if
//
// Purpose: bundles the request/response handshake between the pipeline MEM
// stage and the load/store controller, together with the controller's
// command/data bus towards the byte-addressed data memory.
//
// Signal summary:
//   req_valid/req_ready   request handshake (accepted when both high)
//   req_write             1 = store, 0 = load
//   req_funct3            RV32I size/sign code (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_addr, req_wdata   byte address and store data
//   resp_valid            one-cycle completion pulse
//   resp_err              request faulted (qualified by resp_valid)
//   resp_rdata            load result, 0 for stores and faults
//   dm_we/dm_re           memory write/read enable
//   dm_mode               memory access mode (funct3 encoding)
//   dm_addr, dm_wdata     memory byte address and write data
//   dm_rdata              memory read data, valid the cycle after dm_re
//
// Modports:
//   slave  - the controller
//   master - the environment (pipeline plus memory)
// ---------------------------------------------------------------------------
interface lsu_mem_ctrl_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [2:0]        req_funct3;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_err;
    logic [31:0]       resp_rdata;

    logic              dm_we;
    logic              dm_re;
    logic [2:0]        dm_mode;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;

    modport slave (
        input  req_valid, req_write, req_funct3, req_addr, req_wdata, dm_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
               dm_we, dm_re, dm_mode, dm_addr, dm_wdata
    );

    modport master (
        output req_valid, req_write, req_funct3, req_addr, req_wdata, dm_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
               dm_we, dm_re, dm_mode, dm_addr, dm_wdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Purpose: load/store initiator between the MEM pipeline stage and a
// byte-addressed little-endian data memory. One request is in flight at a
// time. Naturally aligned accesses go out as a single memory command;
// misaligned halfword/word accesses are split into consecutive byte
// commands and the load bytes are reassembled before sign/zero extension.
// Out-of-range addresses and illegal size/direction combinations are
// answered with an error response without touching memory.
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - synchronous active-high reset
//   bus  - lsu_mem_ctrl_if.slave (request, response and memory bus)
//
// Timing for a request accepted in cycle T with N beats:
//   T+1 .. T+N   ISSUE  one memory command per cycle
//   T+N+1        DRAIN  last read data arrives, result formed
//   T+N+2        RESP   resp_valid pulse (a new request may be taken here)
// A faulted request goes straight to RESP at T+1.
// ---------------------------------------------------------------------------
module lsu_mem_ctrl #(
    parameter int ADDR_W = 10
) (
    input logic            clk,
    input logic            rst,
    lsu_mem_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    // Request fields latched at acceptance; the input bus is ignored after that.
    logic              write_q;
    logic [2:0]        funct3_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              split_q;       // access is broken into byte beats
    logic [1:0]        last_beat_q;   // index of the final beat (N-1)
    logic [1:0]        beat_q;        // beat currently on the memory bus

    logic              resp_err_q;
    logic [31:0]       resp_rdata_q;

    // Decode of the incoming request.
    logic              req_ready_c;
    logic              accept;
    logic              addr_out_of_range;
    logic              funct3_illegal;
    logic              store_unsigned;
    logic              req_fault;
    logic              req_split;
    logic [1:0]        req_last_beat;

    // Memory command outputs.
    logic              dm_we_c;
    logic              dm_re_c;
    logic [2:0]        dm_mode_c;
    logic [ADDR_W-1:0] dm_addr_c;
    logic [31:0]       dm_wdata_c;

    // Load data assembly.
    logic              capture_en;
    logic [1:0]        capture_lane;
    logic [31:0]       merged_word;
    logic [31:0]       final_word;
    logic [31:0]       load_result;

    // -----------------------------------------------------------------------
    // Request decode
    // -----------------------------------------------------------------------
    assign req_ready_c = (state_q == ST_IDLE) || (state_q == ST_RESP);
    assign accept      = bus.req_valid && req_ready_c;

    assign addr_out_of_range = |bus.req_addr[31:ADDR_W];
    assign funct3_illegal    = (bus.req_funct3 == 3'b011) ||
                               (bus.req_funct3 == 3'b110) ||
                               (bus.req_funct3 == 3'b111);
    // Unsigned variants only make sense for loads.
    assign store_unsigned    = bus.req_write && bus.req_funct3[2];
    assign req_fault         = addr_out_of_range || funct3_illegal || store_unsigned;

    // funct3[1:0] carries the size: 00 byte, 01 half, 10 word. Bytes never split.
    always_comb begin
        req_split     = 1'b0;
        req_last_beat = 2'd0;
        if ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) begin
            req_split     = 1'b1;
            req_last_beat = 2'd1;
        end else if ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00)) begin
            req_split     = 1'b1;
            req_last_beat = 2'd3;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next state and memory command outputs
    // -----------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        dm_we_c    = 1'b0;
        dm_re_c    = 1'b0;
        dm_mode_c  = 3'b000;
        dm_addr_c  = '0;
        dm_wdata_c = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = req_fault ? ST_RESP : ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                dm_we_c   = write_q;
                dm_re_c   = ~write_q;
                // Beat address wraps naturally at the top of the memory.
                dm_addr_c = addr_q + ADDR_W'(beat_q);
                if (split_q) begin
                    dm_mode_c  = write_q ? 3'b000 : 3'b100;
                    dm_wdata_c = {24'h0, wdata_q[{beat_q, 3'b000} +: 8]};
                end else begin
                    dm_mode_c  = funct3_q;
                    dm_wdata_c = wdata_q;
                end
                if (beat_q == last_beat_q) begin
                    state_d = ST_DRAIN;
                end
            end

            ST_DRAIN: begin
                state_d = ST_RESP;
            end

            ST_RESP: begin
                // Back-to-back: a request taken here skips the IDLE bubble.
                if (accept) begin
                    state_d = req_fault ? ST_RESP : ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request latch, beat counter and response registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q      <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= '0;
            wdata_q      <= 32'h0;
            split_q      <= 1'b0;
            last_beat_q  <= 2'd0;
            beat_q       <= 2'd0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            if (accept) begin
                write_q     <= bus.req_write;
                funct3_q    <= bus.req_funct3;
                addr_q      <= bus.req_addr[ADDR_W-1:0];
                wdata_q     <= bus.req_wdata;
                split_q     <= req_split;
                last_beat_q <= req_last_beat;
                beat_q      <= 2'd0;
                resp_err_q  <= req_fault;
                if (req_fault) begin
                    resp_rdata_q <= 32'h0;
                end
            end else if (state_q == ST_ISSUE) begin
                beat_q <= beat_q + 2'd1;
            end

            if (state_q == ST_DRAIN) begin
                resp_rdata_q <= write_q ? 32'h0 : load_result;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Load byte assembly
    //
    // Read data lags the command by one cycle, so while beat k is on the bus
    // the byte for beat k-1 is arriving; the final byte arrives in DRAIN and
    // is merged combinationally rather than stored first.
    // -----------------------------------------------------------------------
    assign capture_en   = ~write_q && split_q &&
                          (((state_q == ST_ISSUE) && (beat_q != 2'd0)) || (state_q == ST_DRAIN));
    assign capture_lane = (state_q == ST_DRAIN) ? last_beat_q : (beat_q - 2'd1);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q <= 8'h00;
                end else if (accept) begin
                    lane_q <= 8'h00;
                end else if (capture_en && (capture_lane == 2'(gi))) begin
                    lane_q <= bus.dm_rdata[7:0];
                end
            end

            assign merged_word[8*gi +: 8] = (capture_lane == 2'(gi)) ? bus.dm_rdata[7:0] : lane_q;
        end
    endgenerate

    // Unsplit accesses already come back sized and extended by the memory.
    assign final_word = split_q ? merged_word : bus.dm_rdata;

    always_comb begin
        load_result = final_word;
        case (funct3_q)
            3'b001:  load_result = {{16{final_word[15]}}, final_word[15:0]};
            3'b101:  load_result = {16'h0, final_word[15:0]};
            default: load_result = final_word;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign bus.req_ready  = req_ready_c;
    assign bus.resp_valid = (state_q == ST_RESP);
    // The error flag is held after a fault; only show it alongside the pulse.
    assign bus.resp_err   = (state_q == ST_RESP) && resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.dm_we      = dm_we_c;
    assign bus.dm_re      = dm_re_c;
    assign bus.dm_mode    = dm_mode_c;
    assign bus.dm_addr    = dm_addr_c;
    assign bus.dm_wdata   = dm_wdata_c;

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Load/store initiator between the pipeline MEM stage and the byte-addressed, little-endian data memory.
- Accepts one load/store request at a time.
- Issues naturally aligned accesses as a single memory command.
- Splits misaligned halfword/word accesses into sequential byte commands, then reassembles and sign/zero-extends load data.
- Flags out-of-range or illegal requests without touching memory.

Parameters:
- ADDR_W, 10, memory byte-address width; memory holds 2^ADDR_W bytes.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept; a request is accepted when req_valid & req_ready
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr  in  32  byte address
- req_wdata  in  32  store data; low bytes used per size
- resp_valid  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_valid; request faulted
- resp_rdata  out  32  load result (registered); 0 for stores and faults
- dm_we  out  1  memory write enable
- dm_re  out  1  memory read enable
- dm_mode  out  3  memory access mode (same encoding as funct3)
- dm_addr  out  ADDR_W  memory byte address
- dm_wdata  out  32  memory write data
- dm_rdata  in  32  memory read data; registered, valid the cycle after dm_re

Behaviour:
- Reset (any state):
  - state = IDLE; req_ready = 1.
  - resp_valid, resp_err, dm_we, dm_re = 0.
  - resp_rdata, dm_mode, dm_addr, dm_wdata = 0; assembly register = 0.
  - Bytes already written by an interrupted split store remain written.
- States: IDLE, ISSUE, DRAIN, RESP.
  - req_ready = 1 in IDLE and RESP, 0 otherwise.
  - A request is accepted in cycle T.
- Fault check at acceptance. Fault if any of:
  - req_addr[31:ADDR_W] != 0;
  - funct3 is 011, 110 or 111;
  - store with funct3[2] = 1.
  - On fault: go to RESP at T+1 with resp_valid = 1, resp_err = 1, resp_rdata = 0, and no dm_we/dm_re pulse.
- Beat count N:
  - N = 1 if aligned: byte; half with addr[0] = 0; word with addr[1:0] = 00.
  - Otherwise N = 2 for half, N = 4 for word.
- ISSUE, cycles T+1 .. T+N, beat k = 0..N-1:
  - dm_re = ~write, dm_we = write.
  - dm_addr = req_addr[ADDR_W-1:0] + k, wrapping modulo 2^ADDR_W.
  - N = 1: dm_mode = funct3; dm_wdata = req_wdata.
  - N > 1: dm_mode = 100 (bu) for loads, 000 (b) for stores; dm_wdata = {24'b0, req_wdata[8k+7:8k]}.
  - Request fields are latched at acceptance; input changes after T are ignored.
- Load data capture:
  - dm_rdata for beat k is sampled at cycle T+2+k.
  - N = 1: captured whole.
  - N > 1: dm_rdata[7:0] goes into assembly byte lane k.
- DRAIN at cycle T+N+1:
  - dm_we = dm_re = 0.
  - Final load byte/word captured.
  - Extension applied: h sign-extends from bit 15; hu zero-extends; w unchanged.
  - Result written into resp_rdata.
- RESP at cycle T+N+2 (loads and stores alike):
  - resp_valid = 1, resp_err = 0.
  - resp_rdata = result for loads, 0 for stores.
  - Latency: 3 cycles aligned, 4 misaligned half, 6 misaligned word.
- Back-to-back: a request accepted in RESP moves directly to ISSUE (or to RESP on fault) next cycle. resp_valid is high for exactly one cycle per request.
- In IDLE/RESP with no new request: dm_* outputs = 0; resp_rdata holds until the next capture or reset.

Test Plan:
- Aligned word: store 0xDEADBEEF at 0x10, then load 010 at 0x10.
  - Store: single dm_we beat, mode 010, addr 0x10, resp at T+3.
  - Load: resp_rdata = 0xDEADBEEF at T+3.
- Misaligned word: store w 0x11223344 at 0x0FD.
  - Four byte writes at addrs 0x0FD..0x100 with data 44, 33, 22, 11; resp at T+6.
  - Load w at 0x0FD returns 0x11223344, also at T+6.
- Half sign handling: bytes 0x81 at 0x21, 0x80 at 0x22.
  - Load h at 0x21 (split, N = 2) -> 0xFFFF8081 at T+4.
  - Load hu at 0x21 -> 0x00008081.
  - Load b at 0x21 -> 0xFFFFFF81.
- Wrap: load w at 0x3FE -> beats at 0x3FE, 0x3FF, 0x000, 0x001.
- Faults: each of these gives resp_err = 1 at T+1 with no dm_we/dm_re activity:
  - req_addr = 0x400 (ADDR_W = 10);
  - funct3 = 011;
  - store with funct3 = 100.
- Reset mid-split-store: assert rst after beat 1 of a 4-beat store.
  - Next cycle: all outputs 0, req_ready = 1.
  - Bytes 0–1 written, bytes 2–3 unchanged.
  - Back-to-back requests in RESP are accepted with no bubble.
